// File: rtl/scope_pkg.sv
// scope_pkg: definitions shared by the trigger capture slice.
//   - state_e    : capture FSM state encoding
//   - SLOPE_*    : trigger slope select values
//   - DEFAULT_*  : default record geometry and timeout
//   - crossed()  : level-crossing test between two consecutive samples
package scope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE       = 3'd1,
    ST_WAIT_TRIG = 3'd2,
    ST_POST      = 3'd3,
    ST_READ      = 3'd4
  } state_e;

  localparam logic SLOPE_RISE = 1'b0;
  localparam logic SLOPE_FALL = 1'b1;

  localparam int DEFAULT_DEPTH   = 512;
  localparam int DEFAULT_PRETRIG = 128;
  localparam int DEFAULT_TIMEOUT = 65535;

  // Rising: prev below level, cur at/above. Falling: prev above, cur at/below.
  function automatic logic crossed(input logic [7:0] prev, input logic [7:0] cur,
                                   input logic [7:0] level, input logic slope);
    logic res;
    if (slope == SLOPE_RISE) begin
      res = (prev < level) && (cur >= level);
    end else if (slope == SLOPE_FALL) begin
      res = (prev > level) && (cur <= level);
    end else begin
      res = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/trigger_capture_if.sv
// trigger_capture_if: sample input stream and readout stream of the capture buffer.
//   iData/iData_Valid : decimated sample strobe into the buffer
//   oData/oData_Valid : readout sample, held until accepted
//   iData_Ready       : readout accept from the host path
// slave modport = capture buffer side, master modport = driver/host side.
interface trigger_capture_if;
  logic [7:0] iData;
  logic       iData_Valid;
  logic [7:0] oData;
  logic       oData_Valid;
  logic       iData_Ready;

  modport master (output iData, output iData_Valid, output iData_Ready,
                  input  oData, input  oData_Valid);
  modport slave  (input  iData, input  iData_Valid, input  iData_Ready,
                  output oData, output oData_Valid);
endinterface

// File: rtl/capture_ram.sv
// capture_ram: simple dual-port DEPTH x 8 sample store.
//   clk          : clock
//   we/waddr/wdata : synchronous write port
//   re/raddr     : read port; rdata registered one cycle after re, held otherwise
// No reset on the storage or read register so it maps onto block RAM.
module capture_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port; output holds while re is low.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: pre/post-trigger capture buffer with oldest-first readout.
//   iClk, iRst_n  : clock, synchronous active-low reset
//   io (slave)    : sample input stream and valid/ready readout stream
//   iArm, iAbort  : start a capture (IDLE only) / return to IDLE from anywhere
//   iLevel,iSlope : trigger level and slope, latched on arm
//   oBusy         : not IDLE
//   oTriggered    : one-cycle pulse after the trigger sample is accepted
//   oForced       : set by a timeout trigger until the next arm
// Optional feature macro: TRIGGER_TIMEOUT_EN (forced trigger after TIMEOUT
// accepted samples in WAIT_TRIG). Undefined: wait forever, oForced stays 0.
module trigger_capture
  import scope_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int PRETRIG = DEFAULT_PRETRIG,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                iClk,
  input  logic                iRst_n,
  trigger_capture_if.slave    io,
  input  logic                iArm,
  input  logic                iAbort,
  input  logic [7:0]          iLevel,
  input  logic                iSlope,
  output logic                oBusy,
  output logic                oTriggered,
  output logic                oForced
);

  localparam int AW       = $clog2(DEPTH);
  localparam int CW       = AW + 1;
  localparam int POST_LEN = DEPTH - PRETRIG;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, taddr_q, taddr_d, raddr_q, raddr_d;
  logic [CW-1:0] cnt_q, cnt_d, rd_cnt_q, rd_cnt_d;
  logic [7:0]    prev_q, prev_d, level_q, level_d;
  logic          prev_vld_q, prev_vld_d, slope_q, slope_d;
  logic          issue_q, issue_d, dvalid_q, dvalid_d;
  logic          trig_q, trig_d, forced_q, forced_d, busy_q, busy_d;
  logic          we_s, re_s, hit_s, tmo_fire_s;
  logic [7:0]    ram_rdata_s;

  assign hit_s = prev_vld_q && crossed(prev_q, io.iData, level_q, slope_q);

`ifdef TRIGGER_TIMEOUT_EN
  logic [15:0] tmo_q, tmo_d;

  // Count accepted samples while waiting; cleared on arm.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == ST_IDLE && iArm) begin
      tmo_d = 16'd0;
    end else if (state_q == ST_WAIT_TRIG && io.iData_Valid) begin
      tmo_d = tmo_q + 16'd1;
    end else begin
      tmo_d = tmo_q;
    end
  end

  assign tmo_fire_s = (state_q == ST_WAIT_TRIG) && io.iData_Valid && (tmo_d == 16'(TIMEOUT));

  // Timeout counter register.
  always_ff @(posedge iClk) begin
    if (!iRst_n) tmo_q <= 16'd0;
    else         tmo_q <= tmo_d;
  end
`else
  logic [15:0] unused_timeout_s;
  assign unused_timeout_s = 16'(TIMEOUT);
  assign tmo_fire_s       = 1'b0;
`endif

  // FSM next-state, pointer and readout handshake logic.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    taddr_d    = taddr_q;
    raddr_d    = raddr_q;
    cnt_d      = cnt_q;
    rd_cnt_d   = rd_cnt_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    level_d    = level_q;
    slope_d    = slope_q;
    issue_d    = 1'b0;
    dvalid_d   = dvalid_q;
    trig_d     = 1'b0;
    forced_d   = forced_q;
    we_s       = 1'b0;
    re_s       = 1'b0;
    if (iAbort) begin
      state_d  = ST_IDLE;
      dvalid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (iArm) begin
            level_d    = iLevel;
            slope_d    = iSlope;
            wptr_d     = '0;
            cnt_d      = '0;
            prev_vld_d = 1'b0;
            forced_d   = 1'b0;
            state_d    = ST_PRE;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_PRE, ST_WAIT_TRIG, ST_POST: begin
          if (io.iData_Valid) begin
            we_s       = 1'b1;
            wptr_d     = wptr_q + AW'(1);
            prev_d     = io.iData;
            prev_vld_d = 1'b1;
            cnt_d      = cnt_q + CW'(1);
            if (state_q == ST_PRE) begin
              if (cnt_q == CW'(PRETRIG - 1)) begin
                cnt_d   = '0;
                state_d = ST_WAIT_TRIG;
              end else begin
                state_d = ST_PRE;
              end
            end else if (state_q == ST_WAIT_TRIG) begin
              if (hit_s || tmo_fire_s) begin
                // Trigger sample is post sample 1; a genuine crossing beats the timeout.
                taddr_d  = wptr_q;
                trig_d   = 1'b1;
                forced_d = !hit_s;
                cnt_d    = CW'(1);
                if (POST_LEN == 1) begin
                  raddr_d  = wptr_q - AW'(PRETRIG);
                  rd_cnt_d = '0;
                  issue_d  = 1'b1;
                  state_d  = ST_READ;
                end else begin
                  state_d = ST_POST;
                end
              end else begin
                state_d = ST_WAIT_TRIG;
              end
            end else begin
              if (cnt_q == CW'(POST_LEN - 1)) begin
                raddr_d  = taddr_q - AW'(PRETRIG);
                rd_cnt_d = '0;
                issue_d  = 1'b1;
                state_d  = ST_READ;
              end else begin
                state_d = ST_POST;
              end
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_READ: begin
          // Read issued this cycle, data presented next cycle, held until accepted.
          if (issue_q) begin
            re_s     = 1'b1;
            dvalid_d = 1'b1;
          end else if (dvalid_q && io.iData_Ready) begin
            dvalid_d = 1'b0;
            raddr_d  = raddr_q + AW'(1);
            rd_cnt_d = rd_cnt_q + CW'(1);
            if (rd_cnt_q == CW'(DEPTH - 1)) begin
              state_d = ST_IDLE;
            end else begin
              issue_d = 1'b1;
            end
          end else begin
            dvalid_d = dvalid_q;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          dvalid_d = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q    <= ST_IDLE;
      wptr_q     <= '0;
      taddr_q    <= '0;
      raddr_q    <= '0;
      cnt_q      <= '0;
      rd_cnt_q   <= '0;
      prev_q     <= 8'h00;
      prev_vld_q <= 1'b0;
      level_q    <= 8'h00;
      slope_q    <= 1'b0;
      issue_q    <= 1'b0;
      dvalid_q   <= 1'b0;
      trig_q     <= 1'b0;
      forced_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      taddr_q    <= taddr_d;
      raddr_q    <= raddr_d;
      cnt_q      <= cnt_d;
      rd_cnt_q   <= rd_cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      level_q    <= level_d;
      slope_q    <= slope_d;
      issue_q    <= issue_d;
      dvalid_q   <= dvalid_d;
      trig_q     <= trig_d;
      forced_q   <= forced_d;
      busy_q     <= busy_d;
    end
  end

  capture_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (iClk),
    .we    (we_s),
    .waddr (wptr_q),
    .wdata (io.iData),
    .re    (re_s),
    .raddr (raddr_q),
    .rdata (ram_rdata_s)
  );

  // RAM read register has no reset; mask it so oData is 0 whenever not valid.
  assign io.oData       = dvalid_q ? ram_rdata_s : 8'h00;
  assign io.oData_Valid = dvalid_q;
  assign oBusy          = busy_q;
  assign oTriggered     = trig_q;
  assign oForced        = forced_q;

endmodule

// File: tb/tb_trigger_capture.sv
// Directed self-checking bench for trigger_capture (DEPTH=16, PRETRIG=4, TIMEOUT=20).
module tb_trigger_capture;

  localparam int DEPTH   = 16;
  localparam int PRETRIG = 4;
  localparam int TIMEOUT = 20;

  logic       clk;
  logic       rst_n;
  logic       arm;
  logic       abort_in;
  logic [7:0] level;
  logic       slope;
  logic       busy;
  logic       trig;
  logic       forced;

  int n_chk;
  int n_err;
  int n_sent;
  int trig_cnt;
  int trig_at;
  logic [7:0] exp_rec [DEPTH];

  trigger_capture_if bus ();

  trigger_capture #(.DEPTH(DEPTH), .PRETRIG(PRETRIG), .TIMEOUT(TIMEOUT)) dut (
    .iClk       (clk),
    .iRst_n     (rst_n),
    .io         (bus),
    .iArm       (arm),
    .iAbort     (abort_in),
    .iLevel     (level),
    .iSlope     (slope),
    .oBusy      (busy),
    .oTriggered (trig),
    .oForced    (forced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Arm with a valid sample of 0xFF in the same cycle (must not be captured),
  // then scramble level/slope inputs to prove they were latched.
  task automatic arm_cap(input logic [7:0] lvl, input logic slp);
    level = lvl;
    slope = slp;
    arm = 1'b1;
    bus.iData = 8'hFF;
    bus.iData_Valid = 1'b1;
    step();
    arm = 1'b0;
    bus.iData_Valid = 1'b0;
    level = ~lvl;
    slope = ~slp;
    n_sent = 0;
    trig_cnt = 0;
    trig_at = 0;
    check("arm_busy", {31'd0, busy}, 32'd1);
  endtask

  task automatic send(input logic [7:0] d);
    bus.iData = d;
    bus.iData_Valid = 1'b1;
    step();
    bus.iData_Valid = 1'b0;
    n_sent++;
    if (trig) begin
      trig_cnt++;
      trig_at = n_sent;
    end
  endtask

  // Read n samples against exp_rec; mode 1 holds ready low two cycles per sample.
  task automatic read_n(input int n, input int mode, input bit arm_last);
    for (int i = 0; i < n; i++) begin
      for (int w = 0; w < 10 && !bus.oData_Valid; w++) step();
      check("rd_valid", {31'd0, bus.oData_Valid}, 32'd1);
      if (mode == 1) begin
        for (int h = 0; h < 2; h++) begin
          bus.iData_Ready = 1'b0;
          step();
          check("rd_hold_valid", {31'd0, bus.oData_Valid}, 32'd1);
          check("rd_hold_data", {24'd0, bus.oData}, {24'd0, exp_rec[i]});
        end
      end
      check("rd_data", {24'd0, bus.oData}, {24'd0, exp_rec[i]});
      bus.iData_Ready = 1'b1;
      if (arm_last && i == DEPTH - 1) arm = 1'b1;
      step();
      bus.iData_Ready = 1'b0;
      arm = 1'b0;
      check("rd_gap", {31'd0, bus.oData_Valid}, 32'd0);
      if (i == DEPTH - 1) check("rd_done_busy", {31'd0, busy}, 32'd0);
    end
  endtask

  task automatic ramp_capture();
    arm_cap(8'h80, 1'b0);
    for (int k = 0; k < 20; k++) send(8'(k * 16));
    check("t1_trig_cnt", trig_cnt, 32'd1);
    check("t1_trig_at", trig_at, 32'd9);
    for (int i = 0; i < DEPTH; i++) exp_rec[i] = 8'(32'h40 + i * 16);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    arm = 1'b0;
    abort_in = 1'b0;
    level = 8'h00;
    slope = 1'b0;
    bus.iData = 8'h00;
    bus.iData_Valid = 1'b0;
    bus.iData_Ready = 1'b0;
    repeat (3) step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, bus.oData_Valid}, 32'd0);
    check("rst_data", {24'd0, bus.oData}, 32'd0);
    check("rst_trig", {31'd0, trig}, 32'd0);
    check("rst_forced", {31'd0, forced}, 32'd0);
    rst_n = 1'b1;
    step();

    // Rising ramp at 0x80; first read issued W+1, data valid W+2.
    ramp_capture();
    check("t1_w1_valid", {31'd0, bus.oData_Valid}, 32'd0);
    check("t1_w1_busy", {31'd0, busy}, 32'd1);
    check("t1_forced", {31'd0, forced}, 32'd0);
    step();
    check("t1_w2_valid", {31'd0, bus.oData_Valid}, 32'd1);
    read_n(DEPTH, 0, 1'b1);
    step();
    check("t1_arm_ignored", {31'd0, busy}, 32'd0);

    // Falling at 0x40: constant run must not trigger, 0x41->0x40 does.
    arm_cap(8'h40, 1'b1);
    for (int k = 0; k < 8; k++) send(8'h40);
    check("t2_no_trig_const", trig_cnt, 32'd0);
    send(8'h41);
    send(8'h40);
    check("t2_trig_pulse", {31'd0, trig}, 32'd1);
    for (int k = 0; k < 11; k++) send(8'(k + 1));
    check("t2_trig_cnt", trig_cnt, 32'd1);
    check("t2_trig_at", trig_at, 32'd10);
    exp_rec[0] = 8'h40; exp_rec[1] = 8'h40; exp_rec[2] = 8'h40; exp_rec[3] = 8'h41;
    exp_rec[4] = 8'h40;
    for (int i = 5; i < DEPTH; i++) exp_rec[i] = 8'(i - 4);
    read_n(DEPTH, 1, 1'b0);

    // Crossing during PRE ignored; abort mid-POST with a same-cycle sample.
    arm_cap(8'h80, 1'b0);
    send(8'h00); send(8'h90); send(8'h00); send(8'h00);
    check("t3_pre_no_trig", trig_cnt, 32'd0);
    send(8'h00); send(8'hA0);
    check("t3_trig_at", trig_at, 32'd6);
    send(8'h11); send(8'h12);
    abort_in = 1'b1;
    bus.iData_Valid = 1'b1;
    step();
    abort_in = 1'b0;
    bus.iData_Valid = 1'b0;
    check("t3_abort_busy", {31'd0, busy}, 32'd0);
    check("t3_abort_valid", {31'd0, bus.oData_Valid}, 32'd0);

    // Abort mid-READ (with ready high on the abort cycle), then a fresh record.
    ramp_capture();
    read_n(3, 0, 1'b0);
    step();
    check("t5_pre_abort_valid", {31'd0, bus.oData_Valid}, 32'd1);
    abort_in = 1'b1;
    bus.iData_Ready = 1'b1;
    step();
    abort_in = 1'b0;
    bus.iData_Ready = 1'b0;
    check("t5_abort_busy", {31'd0, busy}, 32'd0);
    check("t5_abort_valid", {31'd0, bus.oData_Valid}, 32'd0);
    ramp_capture();
    read_n(DEPTH, 0, 1'b0);

`ifdef TRIGGER_TIMEOUT_EN
    // Constant input never crosses; 20th WAIT_TRIG sample is forced.
    arm_cap(8'h80, 1'b0);
    for (int k = 0; k < PRETRIG + TIMEOUT - 1; k++) send(8'h10);
    check("t6_no_trig_yet", trig_cnt, 32'd0);
    send(8'h10);
    check("t6_forced_pulse", {31'd0, trig}, 32'd1);
    check("t6_forced", {31'd0, forced}, 32'd1);
    for (int k = 0; k < DEPTH - PRETRIG - 1; k++) send(8'h10);
    for (int i = 0; i < DEPTH; i++) exp_rec[i] = 8'h10;
    read_n(DEPTH, 0, 1'b0);
    check("t6_forced_held", {31'd0, forced}, 32'd1);
    arm_cap(8'h80, 1'b0);
    check("t6_forced_clr", {31'd0, forced}, 32'd0);
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
`else
    // Without the timeout feature WAIT_TRIG never gives up.
    arm_cap(8'h80, 1'b0);
    for (int k = 0; k < 40; k++) send(8'h10);
    check("t6_no_timeout", trig_cnt, 32'd0);
    check("t6_still_busy", {31'd0, busy}, 32'd1);
    check("t6_forced_zero", {31'd0, forced}, 32'd0);
    abort_in = 1'b1;
    step();
    abort_in = 1'b0;
`endif
    check("end_idle", {31'd0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/trigger_capture.md
# trigger_capture

Edge-triggered capture buffer sitting directly downstream of the decimation stage in the scope datapath. It consumes decimated 8-bit samples and keeps a pre-trigger history in a ring buffer. It detects a level crossing with programmable slope and fills the post-trigger window. It then streams the full record, oldest sample first, to the host readout path over a valid/ready handshake.

## Interface
- DEPTH, 512: record length in samples; power of two, 16..4096.
- PRETRIG, 128: samples kept before the trigger sample; 1..DEPTH-1.
- TIMEOUT, 65535: accepted samples in WAIT_TRIG before a forced trigger; used only with TRIGGER_TIMEOUT_EN.
- iClk  in  1  sole clock; all logic on rising edge.
- iRst_n  in  1  synchronous, active-low reset.
- iData  in  8  decimated sample.
- iData_Valid  in  1  one-cycle strobe qualifying iData.
- iArm  in  1  start a capture; honoured only in IDLE.
- iAbort  in  1  return to IDLE from any state.
- iLevel  in  8  trigger level, unsigned; latched on arm.
- iSlope  in  1  0 = rising, 1 = falling; latched on arm.
- oData  out  8  readout sample.
- oData_Valid  out  1  oData valid; held until accepted.
- iData_Ready  in  1  downstream accepts oData when high with oData_Valid.
- oBusy  out  1  high in every state except IDLE.
- oTriggered  out  1  one-cycle pulse when the trigger sample is accepted.
- oForced  out  1  high from a timeout trigger until the next arm; constant 0 without TRIGGER_TIMEOUT_EN.

## Operation
- States: IDLE, PRE, WAIT_TRIG, POST, READ.
- IDLE: iArm=1 latches iLevel/iSlope, clears the write pointer, pre-count, and previous-sample-valid flag, then moves to PRE. iData_Valid is ignored.
- PRE: each valid sample is written at wptr and wptr increments mod DEPTH. After the PRETRIG-th write, move to WAIT_TRIG. Triggers are ignored here, but the previous sample is still tracked.
- WAIT_TRIG: each valid sample is written. Rising trigger: prev < level and cur >= level. Falling trigger: prev > level and cur <= level. No trigger is possible while the previous sample is invalid, i.e. on the first sample after arm. On trigger, record taddr = address of the trigger sample and move to POST.
- The trigger sample counts as post sample 1. POST writes until DEPTH-PRETRIG samples total, then moves to READ.
- In WAIT_TRIG the ring overwrites freely; pre-history is always the last PRETRIG samples before the trigger.
- READ: start at raddr = (taddr - PRETRIG) mod DEPTH and stream exactly DEPTH samples, wrapping mod DEPTH. iData_Valid is ignored. After the last handshake, return to IDLE.
- Readout flow: issue a RAM read, present oData with oData_Valid the next cycle, hold both stable until iData_Ready=1, then advance. Maximum rate is 1 sample per 2 cycles.
- iAbort takes priority over every other event, including iArm and a same-cycle trigger. The next state is IDLE, oData_Valid=0, and any partial record is discarded.
- Reset: all outputs 0, state IDLE, pointers 0.

## Timing
- Trigger sample accepted at cycle T: oTriggered=1 at T+1, state POST at T+1.
- Last POST write at cycle W: state READ at W+1 (read issued), first oData_Valid at W+2.
- A handshake at cycle H issues the next read at H+1 and raises oData_Valid at H+2. oData_Valid is low at H+1.
- Last handshake at cycle L: oBusy=0 and state IDLE at L+1.
- iArm asserted during the same cycle as the final handshake is ignored.
- iArm accepted at cycle A: oBusy=1 at A+1. A sample at A is not captured.

## Configuration
- TRIGGER_TIMEOUT_EN defined: a 16-bit counter counts accepted samples in WAIT_TRIG. When it reaches TIMEOUT, the current sample is treated as the trigger sample, oTriggered pulses, and oForced sets. A genuine trigger on that same sample wins and oForced stays 0.
- TRIGGER_TIMEOUT_EN undefined: no counter. WAIT_TRIG waits indefinitely, oForced is tied 0, and TIMEOUT is unused.

## Structure
- Shared package scope_pkg: state encoding constants, slope constants (SLOPE_RISE=0, SLOPE_FALL=1), and default DEPTH/PRETRIG.
- One sub-module, capture_ram: simple dual-port, DEPTH x 8, synchronous write, registered 1-cycle read, inferable to iCE40 EBR.
- The FSM, pointers, and comparator live in trigger_capture.

## Test plan
- DEPTH=16, PRETRIG=4, rising at level 0x80; ramp 0x00,0x10,...,0xF0 repeating, then read with iData_Ready=1 -> trigger on 0x80, and readout is 0x40,0x50,0x60,0x70,0x80,...,0xF0,0x00,...,0x30 (16 samples). Only the first crossing triggers.
- Falling slope, level 0x40, constant 0x40 then 0x41, 0x40 -> no trigger on the constant run; trigger on the 0x41->0x40 sample.
- Crossing within the first PRETRIG samples after arm -> ignored. The trigger fires on the first crossing after PRE completes.
- Readout with iData_Ready toggling 1-of-3 cycles -> oData stable while unaccepted, exactly DEPTH handshakes, oBusy falls 1 cycle after the last one.
- iAbort mid-POST and mid-READ -> IDLE next cycle, oData_Valid=0, and a fresh iArm yields a correct full record.
- With TRIGGER_TIMEOUT_EN, TIMEOUT=20, constant input 0x10 -> forced trigger on the 20th WAIT_TRIG sample, oForced=1, full record read.
